// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer handlers.
// Gray/binary helpers work on a wide zero-extended word, so one function
// serves any pointer width up to GRAY_WORD_W bits. Callers cast the result
// back down to their own pointer width.
package async_fifo_pkg;

  localparam int DEFAULT_PTR_WIDTH = 3;
  localparam int GRAY_WORD_W       = 32;

  typedef logic [DEFAULT_PTR_WIDTH:0] ptr_t;
  typedef logic [GRAY_WORD_W-1:0]     gray_word_t;

  // Binary to reflected Gray code.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary. Each binary bit is the XOR of all Gray
  // bits at or above it. Zero upper bits leave the lower result unchanged.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_WORD_W-1] = g[GRAY_WORD_W-1];
    for (int i = GRAY_WORD_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Reset is synchronous and active-high in the destination domain.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] q_r;

  // First and second synchronizer stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= {WIDTH{1'b0}};
      q_r  <= {WIDTH{1'b0}};
    end else begin
      s1_r <= d;
      q_r  <= s1_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/rptr_handler.sv
// Read-side pointer handler of the asynchronous FIFO.
// Synchronizes the Gray write pointer into rclk, keeps the binary and Gray
// read pointers, and produces registered empty / underflow.
// Macro RPTR_LEVEL_EN: when defined, also builds the gray-to-binary converter
// with a conservative rd_level and almost_empty; when undefined, rd_level is
// tied to zero and almost_empty mirrors empty.
module rptr_handler
  import async_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = async_fifo_pkg::DEFAULT_PTR_WIDTH,
  parameter int AE_THRESH = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               r_en,
  input  logic [PTR_WIDTH:0] g_wptr_async,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic               empty,
  output logic [PTR_WIDTH:0] rd_level,
  output logic               almost_empty,
  output logic               underflow
);

  typedef logic [PTR_WIDTH:0] rptr_t;
  localparam rptr_t PTR_ZERO = {(PTR_WIDTH+1){1'b0}};

  rptr_t g_wptr_sync_s;
  rptr_t b_rptr_next_s;
  rptr_t g_rptr_next_s;
  logic  empty_next_s;
  rptr_t b_rptr_r;
  rptr_t g_rptr_r;
  logic  empty_r;
  logic  underflow_r;

  sync_2ff #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_wptr_sync (
    .clk(rclk),
    .rst(rrst),
    .d  (g_wptr_async),
    .q  (g_wptr_sync_s)
  );

  // Next read pointer: advances only on a read while not empty.
  always_comb begin
    b_rptr_next_s = b_rptr_r + rptr_t'(r_en & ~empty_r);
    g_rptr_next_s = rptr_t'(bin2gray(gray_word_t'(b_rptr_next_s)));
    // Full-width compare, wrap bit included.
    empty_next_s  = (g_rptr_next_s == g_wptr_sync_s);
  end

  // Pointer, empty and underflow registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr_r    <= PTR_ZERO;
      g_rptr_r    <= PTR_ZERO;
      empty_r     <= 1'b1;
      underflow_r <= 1'b0;
    end else begin
      b_rptr_r    <= b_rptr_next_s;
      g_rptr_r    <= g_rptr_next_s;
      empty_r     <= empty_next_s;
      underflow_r <= r_en & empty_r;
    end
  end

  assign b_rptr    = b_rptr_r;
  assign g_rptr    = g_rptr_r;
  assign empty     = empty_r;
  assign underflow = underflow_r;

`ifdef RPTR_LEVEL_EN
  rptr_t level_next_s;
  logic  ae_next_s;
  rptr_t rd_level_r;
  logic  almost_empty_r;

  // Level against the stale synchronized write pointer; can only under-report.
  always_comb begin
    level_next_s = rptr_t'(gray2bin(gray_word_t'(g_wptr_sync_s))) - b_rptr_next_s;
    ae_next_s    = (int'(level_next_s) <= AE_THRESH);
  end

  // Level and almost-empty registers, updating alongside empty.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_level_r     <= PTR_ZERO;
      almost_empty_r <= 1'b1;
    end else begin
      rd_level_r     <= level_next_s;
      almost_empty_r <= ae_next_s;
    end
  end

  assign rd_level     = rd_level_r;
  assign almost_empty = almost_empty_r;
`else
  assign rd_level     = PTR_ZERO;
  assign almost_empty = empty_r;
`endif

endmodule

// File: tb/tb_rptr_handler.sv
// Self-checking bench for rptr_handler: directed scenarios followed by
// randomized reads/writes, all compared against an occupancy-level model
// that tracks plain integer pointers.
module tb_rptr_handler;

  localparam int PW  = 3;
  localparam int AE  = 2;
  localparam int MOD = 16;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       r_en;
  logic [3:0] g_wptr_async;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic       empty;
  logic [3:0] rd_level;
  logic       almost_empty;
  logic       underflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: integer write pointer, two-stage sync delay, read count.
  int wbin = 0;
  int m_s1 = 0, m_sync = 0, m_r = 0;
  int m_empty = 1, m_level = 0, m_ae = 1, m_uf = 0;

  rptr_handler #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .r_en        (r_en),
    .g_wptr_async(g_wptr_async),
    .b_rptr      (b_rptr),
    .g_rptr      (g_rptr),
    .empty       (empty),
    .rd_level    (rd_level),
    .almost_empty(almost_empty),
    .underflow   (underflow)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic set_w(input int b);
    wbin = b % MOD;
    g_wptr_async = 4'(to_gray(wbin));
  endtask

  task automatic model_edge();
    int adv;
    if (rrst) begin
      m_r = 0; m_s1 = 0; m_sync = 0;
      m_empty = 1; m_level = 0; m_ae = 1; m_uf = 0;
    end else begin
      adv     = (r_en && m_empty == 0) ? 1 : 0;
      m_uf    = (r_en && m_empty == 1) ? 1 : 0;
      m_r     = (m_r + adv) % MOD;
      m_empty = (m_r == m_sync) ? 1 : 0;
      m_level = (m_sync - m_r + MOD) % MOD;
      m_ae    = (m_level <= AE) ? 1 : 0;
      m_sync  = m_s1;
      m_s1    = wbin;
    end
  endtask

  task automatic compare_all();
    check("b_rptr", b_rptr, m_r);
    check("g_rptr", g_rptr, to_gray(m_r));
    check("empty", empty, m_empty);
    check("underflow", underflow, m_uf);
`ifdef RPTR_LEVEL_EN
    check("rd_level", rd_level, m_level);
    check("almost_empty", almost_empty, m_ae);
`else
    check("rd_level", rd_level, 0);
    check("almost_empty", almost_empty, m_empty);
`endif
  endtask

  task automatic step(input logic en);
    r_en = en;
    @(posedge rclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic write_to(input int target);
    for (int k = 0; k < 32 && wbin != (target % MOD); k++) begin
      set_w(wbin + 1);
      step(1'b0);
    end
  endtask

  task automatic drain_to(input int target);
    for (int k = 0; k < 40 && m_r != target; k++) step(1'b1);
    check("drain_to", b_rptr, target);
  endtask

  initial begin
    rrst = 1'b1;
    r_en = 1'b1;
    set_w(0);

    // Reset held two cycles with a read request pending.
    step(1'b1);
    step(1'b1);
    check("rst_b_rptr", b_rptr, 0);
    check("rst_g_rptr", g_rptr, 0);
    check("rst_empty", empty, 1);
    check("rst_level", rd_level, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_uf", underflow, 0);
    rrst = 1'b0;

    // Fill to 3: empty falls on the third edge.
    set_w(3);
    step(1'b0);
    step(1'b0);
    check("fill_empty_e2", empty, 1);
    step(1'b0);
    check("fill_empty_e3", empty, 0);
`ifdef RPTR_LEVEL_EN
    check("fill_level", rd_level, 3);
`endif
    // Drain three words.
    step(1'b1);
    check("drain1_b", b_rptr, 1);
    check("drain1_g", g_rptr, 4'b0001);
    step(1'b1);
    check("drain2_b", b_rptr, 2);
    check("drain2_g", g_rptr, 4'b0011);
    step(1'b1);
    check("drain3_b", b_rptr, 3);
    check("drain3_g", g_rptr, 4'b0010);
    check("drain3_empty", empty, 1);

    // Underflow: one pulse per request, pointers hold.
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("uf_pulse", underflow, 1);
      check("uf_hold", b_rptr, 3);
    end
    step(1'b0);
    check("uf_clear", underflow, 0);

    // Almost-empty at threshold 2: level 4, read twice.
    write_to(7);
    idle(3);
`ifdef RPTR_LEVEL_EN
    check("ae_level4", rd_level, 4);
`endif
    step(1'b1);
`ifdef RPTR_LEVEL_EN
    check("ae_l3_level", rd_level, 3);
    check("ae_l3", almost_empty, 0);
`endif
    step(1'b1);
`ifdef RPTR_LEVEL_EN
    check("ae_l2_level", rd_level, 2);
    check("ae_l2", almost_empty, 1);
`endif
    check("mid_b5", b_rptr, 5);

    // Reset mid-drain with r_en high.
    rrst = 1'b1;
    step(1'b1);
    check("mrst_b", b_rptr, 0);
    check("mrst_g", g_rptr, 0);
    check("mrst_empty", empty, 1);
    check("mrst_level", rd_level, 0);
    check("mrst_ae", almost_empty, 1);
    check("mrst_uf", underflow, 0);
    rrst = 1'b0;
    // Cleared sync flops keep empty high for two more edges.
    step(1'b0);
    step(1'b0);
    check("mrst_sync_clear", empty, 1);
    step(1'b0);
    check("mrst_refill", empty, 0);

    // Wrap-around: read pointer at 15, write pointer at 1.
    rrst = 1'b1;
    set_w(0);
    step(1'b0);
    step(1'b0);
    rrst = 1'b0;
    write_to(8);
    idle(3);
    drain_to(8);
    write_to(15);
    idle(3);
    drain_to(15);
    write_to(1);
    idle(3);
    step(1'b1);
    check("wrap1_b", b_rptr, 0);
    check("wrap1_g", g_rptr, 4'b0000);
    check("wrap1_empty", empty, 0);
`ifdef RPTR_LEVEL_EN
    check("wrap1_level", rd_level, 1);
`endif
    step(1'b1);
    check("wrap2_b", b_rptr, 1);
    check("wrap2_empty", empty, 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rrst = ($urandom_range(0, 199) == 0);
      if (rrst) begin
        set_w(0);
      end else if (((wbin - m_r + MOD) % MOD) < 8 && $urandom_range(0, 1) == 1) begin
        set_w(wbin + 1);
      end
      step(1'($urandom_range(0, 1)));
    end
    rrst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rptr_handler.md
# rptr_handler

Read-side pointer handler for the asynchronous FIFO, the counterpart of the write-pointer logic. It sits in the read clock domain and brings the Gray-coded write pointer across with a two-flop synchronizer. It keeps the binary and Gray read pointers and produces a registered `empty` flag, plus an optional fill level and almost-empty indication. The FIFO memory is read at `b_rptr[PTR_WIDTH-1:0]`.

## Interface
Parameters:
- `PTR_WIDTH`, 3: address width; pointers are `PTR_WIDTH+1` bits and depth is `2**PTR_WIDTH`.
- `AE_THRESH`, 1: `almost_empty` asserts when the level is `<= AE_THRESH`.

Ports:
- `rclk`  in  1  read clock; the only clock in this block.
- `rrst`  in  1  reset; synchronous and active-high.
- `r_en`  in  1  read request.
- `g_wptr_async`  in  PTR_WIDTH+1  Gray write pointer driven from the write domain, not yet synchronized.
- `b_rptr`  out  PTR_WIDTH+1  binary read pointer.
- `g_rptr`  out  PTR_WIDTH+1  Gray read pointer, sent to the write domain.
- `empty`  out  1  FIFO empty, registered.
- `rd_level`  out  PTR_WIDTH+1  conservative occupancy.
- `almost_empty`  out  1  level at or below `AE_THRESH`.
- `underflow`  out  1  one-cycle pulse when a read is attempted while empty.

## Operation
- Synchronizer: `g_wptr_s1 <= g_wptr_async`, then `g_wptr_sync <= g_wptr_s1`. Both reset to 0.
- `b_rptr_next = b_rptr + (r_en & ~empty)`.
- `g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next`.
- Registered updates: `b_rptr <= b_rptr_next`, `g_rptr <= g_rptr_next`, `empty <= (g_rptr_next == g_wptr_sync)`.
- Level: `rd_level <= gray2bin(g_wptr_sync) - b_rptr_next`, modulo `2**(PTR_WIDTH+1)`.
  - The synchronized write pointer is stale, so the level can only under-report.
- `almost_empty <= (level_next <= AE_THRESH)`.
- `underflow <= r_en & empty`. Pointers hold while empty, so a read when empty is a no-op on the pointers.
- Wrap-around: pointers roll from `2**(PTR_WIDTH+1)-1` to 0 silently. The MSB/wrap bit is included in the empty compare.
- Reset values: `b_rptr` = 0, `g_rptr` = 0, `empty` = 1, `rd_level` = 0, `almost_empty` = 1, `underflow` = 0, both sync flops = 0.
- Reset mid-operation: `rrst` overrides `r_en`. All registers take their reset values on the next `rclk` edge.

## Timing
- Read pointers advance on the `rclk` edge where `r_en & ~empty` is sampled.
- `empty` rises on the same edge that the last valid word's pointer increments, with no extra cycle.
- Write-side progress to `empty` falling takes 3 `rclk` edges after `g_wptr_async` is stable: two sync flops plus the empty register.
- `rd_level` and `almost_empty` update on the same edge as `empty`.
- `g_wptr_async` may change at most one bit per write clock; this is guaranteed by Gray coding.

## Configuration
- Macro `RPTR_LEVEL_EN`.
  - Defined: the gray-to-binary converter, `rd_level` and `almost_empty` are built as described above.
  - Undefined: `rd_level` is tied to 0 and `almost_empty` is driven as a copy of `empty`. No converter logic is synthesized.
- Pointers, `empty` and `underflow` are identical in both configurations.

## Structure
- Shared package `async_fifo_pkg` holds:
  - default `PTR_WIDTH`;
  - pointer type `ptr_t` (width `PTR_WIDTH+1`);
  - functions `bin2gray` and `gray2bin`, used by both the read and write handlers.
- Sub-module `sync_2ff`: a parameterized-width two-flop synchronizer with synchronous active-high reset. It is reused by the write side for `g_rptr`.

## Test plan
- Reset: hold `rrst`=1 for 2 cycles with `r_en`=1.
  - Expect `b_rptr`=0, `g_rptr`=0, `empty`=1, `rd_level`=0, `almost_empty`=1, `underflow`=0.
- Fill then drain: drive `g_wptr_async`=4'b0010 (binary 3).
  - `empty` falls on the 3rd edge, with `rd_level`=3.
  - Then three `r_en` cycles: `b_rptr` goes 1,2,3 and `g_rptr` goes 0001,0011,0010.
  - `empty`=1 on the edge where `b_rptr` becomes 3.
- Underflow: `r_en`=1 while `empty`=1.
  - Pointers hold; `underflow`=1 for exactly one cycle per sampled request.
- Wrap: read pointer at 15 (Gray 1000), write pointer at binary 1 (Gray 0001), one read.
  - `b_rptr`=0 and `g_rptr`=0000; `empty` stays 0 because `rd_level`=1.
  - A second read gives `b_rptr`=1 and `empty`=1.
- Almost-empty with `AE_THRESH`=2: level 4, read twice.
  - `almost_empty` is 0 at level 3 and 1 at level 2.
- Reset mid-drain: `rrst`=1 at `b_rptr`=5 with `r_en`=1.
  - All outputs return to reset values on the next edge, and the sync flops clear.
